weight_readout: RTL and testbench
=================================

Name: weight_readout

Overview:
- Reader side of the per-unit `control_out` weight tap.
- Samples the `control_out` bit of NUM_UNITS units over a fixed window of oscillator-qualified cycles.
- Counts the ones per unit, giving a stochastic weight estimate.
- Streams one (index, count) word per unit to the host/debug path over a valid/ready handshake.
- Sits beside the unit array; read-only: no unit inputs are driven.

Parameters:
- NUM_UNITS, 8, number of `control_out` taps sampled.
- SAMPLE_CYCLES, 256, oscillator-high cycles per sampling window (must be >= 1).
- CNT_W, $clog2(SAMPLE_CYCLES+1), count width (derived; 9 at defaults).
- IDX_W, $clog2(NUM_UNITS) with minimum 1, index width (derived).

Ports:
- clk_in  input  1  system clock. One clock; reset is synchronous and active-high.
- rst_in  input  1  synchronous, active-high reset.
- oscillator  input  1  sample qualifier; a window cycle is counted only when high.
- start  input  1  one-cycle request to begin a readout; honoured only in IDLE.
- control_in  input  NUM_UNITS  `control_out` bits of the units; bit i belongs to unit i.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  count word available.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_index  output  IDX_W  unit index of the current word.
- out_count  output  CNT_W  number of qualified cycles on which control_in[out_index] was 1.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state IDLE; all counters, the window counter and the drain index are 0; busy=0, out_valid=0, out_index=0, out_count=0, done=0.
- Reset mid-operation aborts immediately, with no done pulse.
- FSM states: IDLE, SAMPLE, DRAIN, FINISH.
- IDLE:
  - start=1 clears all per-unit counters and the window counter.
  - Next state is SAMPLE; busy rises on the following cycle.
  - start outside IDLE is ignored.
- SAMPLE:
  - On each cycle with oscillator=1: every counter i increments iff control_in[i]=1, and the window counter increments.
  - Cycles with oscillator=0 change nothing.
  - On the qualified cycle that brings the window count to SAMPLE_CYCLES, go to DRAIN. That cycle's sample is included.
  - The first possible sample is the cycle after start.
- Counters never overflow: the maximum value is SAMPLE_CYCLES, which fits in CNT_W. No saturation logic is needed.
- DRAIN:
  - out_valid=1, out_index=drain index, out_count=counter[drain index], all registered.
  - Starts with index 0; out_valid rises on the first DRAIN cycle.
  - out_index and out_count hold stable while out_valid && !out_ready.
  - On acceptance with index < NUM_UNITS-1: index+1, and the next word is presented the following cycle. There is no bubble; back-to-back acceptance yields one word per cycle.
  - On acceptance of index NUM_UNITS-1: out_valid drops next cycle; go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=1; next state IDLE.
- A start asserted during FINISH is ignored. The earliest new start is honoured in the first IDLE cycle.
- control_in and oscillator are sampled directly. They are synchronous to clk_in, so no synchroniser is needed.
- Words appear strictly in index order 0..NUM_UNITS-1. No word is dropped or duplicated.

Decomposition:
- Package `bitnet_readout_pkg`:
  - state enum `readout_state_t` {IDLE, SAMPLE, DRAIN, FINISH};
  - function `cnt_width(n)` returning $clog2(n+1).
- Sub-module `ones_counter` (clk_in, rst_in, clear, en, bit_in, count): CNT_W-wide, synchronous clear, increments when en && bit_in. Instantiate NUM_UNITS copies via generate.
- FSM, window counter and drain mux stay in weight_readout.

Test Plan:
- Defaults, oscillator tied 1, control_in = 8'b1010_0101 constant, start pulse, out_ready=1:
  - busy high the cycle after start;
  - words arrive as (0,256),(1,0),(2,256),(3,0),(4,0),(5,256),(6,0),(7,256) on 8 consecutive cycles;
  - then done one cycle, then busy=0.
- oscillator toggles 1,0,1,0..., control_in[3]=1 only while oscillator=0, others 0 -> all counts 0; window completes after 512 clock cycles.
- Backpressure, SAMPLE_CYCLES=4, control_in all 1: out_ready low for 3 cycles at index 2 -> out_index=2 and out_count=4 held stable; resumes at index 3; exactly 8 words; done once.
- start pulsed during SAMPLE and during DRAIN -> no restart, counts unchanged. start on the cycle after done -> new window begins with counters cleared.
- rst_in asserted mid-DRAIN at index 4 -> next cycle out_valid=0, busy=0, done=0, out_index=0, out_count=0. A fresh start produces a full 8-word sequence from index 0.
- NUM_UNITS=1, SAMPLE_CYCLES=1, control_in=1 on the single qualified cycle -> one word (0,1), then done; IDX_W=1.

Source files
------------

// File: rtl/bitnet_readout_pkg.sv
// rtl/bitnet_readout_pkg.sv - shared types and helpers for the weight readout block
//
// Purpose: readout FSM state encoding and the count-width helper used by
// weight_readout and ones_counter.
// Ports: none (package).

package bitnet_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } readout_state_t;

  // Width needed to hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ones_counter.sv
// rtl/ones_counter.sv - per-unit ones counter for one control_out tap
//
// Purpose: counts the cycles on which en && bit_in, with a synchronous clear.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-high reset
//   clear   - synchronous clear to zero (start of a window)
//   en      - qualified sample cycle
//   bit_in  - control_out bit of the unit
//   count   - CNT_W-bit ones count

module ones_counter
  import bitnet_readout_pkg::*;
#(
  parameter int CNT_W = cnt_width(256)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  // The window length bounds the count, so no saturation is needed.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      count <= '0;
    end else if (en && bit_in) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/weight_readout.sv
// rtl/weight_readout.sv - samples per-unit control_out taps and streams weight counts
//
// Purpose: over a window of SAMPLE_CYCLES oscillator-high cycles, counts the
// ones on each unit's control_out tap, then streams one (index, count) word
// per unit over a valid/ready handshake. Read-only beside the unit array.
// Ports:
//   clk_in      - system clock
//   rst_in      - synchronous active-high reset
//   oscillator  - sample qualifier; only high cycles count toward the window
//   start       - one-cycle readout request, honoured only in IDLE
//   control_in  - control_out bits of the units (bit i = unit i)
//   busy        - high in every state except IDLE
//   out_valid   - count word available
//   out_ready   - consumer accepts the word when out_valid && out_ready
//   out_index   - unit index of the current word
//   out_count   - ones count of unit out_index over the window
//   done        - one-cycle pulse after the last word is accepted

module weight_readout
  import bitnet_readout_pkg::*;
#(
  parameter  int NUM_UNITS     = 8,
  parameter  int SAMPLE_CYCLES = 256,
  localparam int CNT_W         = cnt_width(SAMPLE_CYCLES),
  localparam int IDX_W         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 oscillator,
  input  logic                 start,
  input  logic [NUM_UNITS-1:0] control_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_index,
  output logic [CNT_W-1:0]     out_count,
  output logic                 done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_UNITS - 1);
  localparam logic [CNT_W-1:0] LAST_WIN  = CNT_W'(SAMPLE_CYCLES - 1);

  readout_state_t   r_state;
  logic [CNT_W-1:0] r_win;
  logic             r_busy;
  logic             r_valid;
  logic [IDX_W-1:0] r_index;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic             w_clear;
  logic             w_en;
  logic [IDX_W-1:0] w_next_idx;
  logic [CNT_W-1:0] w_count [NUM_UNITS];

  assign w_clear    = (r_state == IDLE) && start;
  assign w_en       = (r_state == SAMPLE) && oscillator;
  assign w_next_idx = r_index + IDX_W'(1);

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    ones_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (w_clear),
      .en     (w_en),
      .bit_in (control_in[g]),
      .count  (w_count[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_win   <= '0;
            r_busy  <= 1'b1;
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (oscillator) begin
            r_win <= r_win + CNT_W'(1);
            if (r_win == LAST_WIN) begin
              // Unit 0's counter takes this final sample on the same edge,
              // so fold it into the registered word here.
              r_state <= DRAIN;
              r_valid <= 1'b1;
              r_index <= '0;
              r_count <= w_count[0] + CNT_W'(control_in[0]);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_index == LAST_IDX) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_index <= w_next_idx;
              r_count <= w_count[w_next_idx];
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_index = r_index;
  assign out_count = r_count;
  assign done      = r_done;

endmodule

// File: tb/tb_weight_readout.sv
// tb/tb_weight_readout.sv - scoreboard testbench for weight_readout

module tb_weight_readout;

  localparam int N  = 8;
  localparam int S  = 256;
  localparam int CW = 9;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          osc = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic [N-1:0]  ctrl = '0;
  logic          busy, valid, done;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  logic          s_osc = 1'b0;
  logic          s_start = 1'b0;
  logic          s_ready = 1'b1;
  logic [0:0]    s_ctrl = '0;
  logic          s_busy, s_valid, s_done;
  logic [0:0]    s_idx;
  logic [0:0]    s_cnt;

  weight_readout #(.NUM_UNITS(N), .SAMPLE_CYCLES(S)) dut (
    .clk_in(clk), .rst_in(rst), .oscillator(osc), .start(start),
    .control_in(ctrl), .busy(busy), .out_valid(valid), .out_ready(ready),
    .out_index(idx), .out_count(cnt), .done(done)
  );

  weight_readout #(.NUM_UNITS(1), .SAMPLE_CYCLES(1)) dut_small (
    .clk_in(clk), .rst_in(rst), .oscillator(s_osc), .start(s_start),
    .control_in(s_ctrl), .busy(s_busy), .out_valid(s_valid), .out_ready(s_ready),
    .out_index(s_idx), .out_count(s_cnt), .done(s_done)
  );

  typedef struct {
    int idx;
    int cnt;
  } word_t;

  word_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int words = 0;
  int first_valid_cyc = 0;
  int last_acc_cyc = -10;
  int done_cnt = 0;
  int stall_seen = 0;
  int stalls = 0;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [IW-1:0] prev_idx = '0;
  logic [CW-1:0] prev_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word, checks handshake rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", int'(valid), 1);
        check("hold_index", int'(idx), int'(prev_idx));
        check("hold_count", int'(cnt), int'(prev_cnt));
      end
      if (valid && !prev_valid) first_valid_cyc = cyc;
      if (valid && !ready && idx == 2) stall_seen++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("word_expected", 0, 1);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("word_index", int'(idx), w.idx);
          check("word_count", int'(cnt), w.cnt);
        end
        words++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        check("done_after_last_accept", cyc, last_acc_cyc + 1);
        check("done_queue_empty", exp_q.size(), 0);
        check("busy_during_done", int'(busy), 1);
        done_cnt++;
      end
    end
    prev_valid <= valid;
    prev_ready <= ready;
    prev_idx   <= idx;
    prev_cnt   <= cnt;
  end

  task automatic drive_ready(input int rmode);
    if (rmode == 0) begin
      ready = 1'b1;
    end else if (rmode == 1) begin
      ready = ($urandom_range(0, 3) != 0);
    end else begin
      if (valid && idx == 2 && stalls < 3) begin
        ready = 1'b0;
        stalls++;
      end else begin
        ready = 1'b1;
      end
    end
  endtask

  // mode 0: oscillator tied high, control_in = cval
  // mode 1: oscillator toggles 1,0,..., control_in[3] high only while oscillator low
  // mode 2: random oscillator and control_in
  // Called and returns at 2 time units after a rising edge, with the DUT idle.
  task automatic run_window(input int mode, input int rmode, input bit noise,
                            input bit abort, input logic [N-1:0] cval);
    int q;
    int e[N];
    int t0;
    int d0;
    bit got_done;
    word_t w;
    q = 0;
    got_done = 0;
    for (int i = 0; i < N; i++) e[i] = 0;
    stalls = 0;
    words = 0;
    stall_seen = 0;
    d0 = done_cnt;

    check("idle_before_start", int'(busy), 0);
    start = 1'b1;
    osc = $urandom_range(0, 1);
    ctrl = N'($urandom);
    drive_ready(rmode);
    t0 = cyc + 1;

    for (int k = 0; k < 4000 && q < S; k++) begin
      @(posedge clk); #2;
      if (k == 0) check("busy_after_start", int'(busy), 1);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 0) begin
        osc = 1'b1;
        ctrl = cval;
      end else if (mode == 1) begin
        osc = (k % 2 == 0);
        ctrl = osc ? N'(0) : N'(8'h08);
      end else begin
        osc = $urandom_range(0, 1);
        ctrl = N'($urandom);
      end
      drive_ready(rmode);
      if (osc) begin
        q++;
        for (int i = 0; i < N; i++) e[i] += int'(ctrl[i]);
      end
    end
    if (q < S) check("window_completes", q, S);
    for (int i = 0; i < N; i++) begin
      w.idx = i;
      w.cnt = e[i];
      exp_q.push_back(w);
    end

    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      start = (noise && valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      osc = $urandom_range(0, 1);
      ctrl = N'($urandom);
      drive_ready(rmode);
      if (abort && valid && idx == 4) begin
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #2;
        check("abort_valid", int'(valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_index", int'(idx), 0);
        check("abort_count", int'(cnt), 0);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (done) begin
        got_done = 1;
        break;
      end
    end
    if (!got_done) begin
      check("done_seen", 0, 1);
      return;
    end
    check("words_per_window", words, N);
    if (mode == 0 && rmode == 0) begin
      check("first_word_latency", first_valid_cyc - t0, S);
      check("back_to_back_words", last_acc_cyc - first_valid_cyc, N - 1);
    end
    if (mode == 1) check("toggle_window_latency", first_valid_cyc - t0, 2 * S - 1);
    if (rmode == 2) check("stall_cycles_at_index2", stall_seen, 3);
    @(posedge clk); #2;
    check("busy_after_finish", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_done", int'(done), 0);
    check("reset_index", int'(idx), 0);
    check("reset_count", int'(cnt), 0);
    rst = 1'b0;

    run_window(0, 0, 0, 0, 8'hA5);
    run_window(1, 0, 0, 0, 8'h00);
    run_window(0, 2, 0, 0, 8'hFF);
    for (int r = 0; r < 3; r++) run_window(2, 1, 1, 0, 8'h00);
    run_window(0, 0, 1, 1, N'($urandom));
    run_window(2, 0, 0, 0, 8'h00);

    s_start = 1'b1;
    @(posedge clk); #2;
    s_start = 1'b0;
    s_osc = 1'b1;
    s_ctrl = 1'b1;
    s_ready = 1'b1;
    @(posedge clk); #2;
    s_osc = 1'b0;
    s_ctrl = 1'b0;
    check("small_valid", int'(s_valid), 1);
    check("small_index", int'(s_idx), 0);
    check("small_count", int'(s_cnt), 1);
    check("small_busy", int'(s_busy), 1);
    @(posedge clk); #2;
    check("small_valid_drop", int'(s_valid), 0);
    check("small_done", int'(s_done), 1);
    @(posedge clk); #2;
    check("small_done_clear", int'(s_done), 0);
    check("small_busy_clear", int'(s_busy), 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
